// File: rtl/rf_nwr_nrd_guarded_if.sv
// rtl/rf_nwr_nrd_guarded_if.sv - transport-bus bundle for the multi-port guarded register file
interface rf_nwr_nrd_guarded_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic                       io_glock;
  logic [NUM_WR-1:0]          io_t_load;
  logic [NUM_WR*ADDR_W-1:0]   io_t_opcode;
  logic [NUM_WR*DATA_W-1:0]   io_t_data;
  logic [NUM_RD-1:0]          io_r_load;
  logic [NUM_RD*ADDR_W-1:0]   io_r_opcode;
  logic [NUM_RD*DATA_W-1:0]   io_r_data;
  logic [DEPTH-1:0]           io_guard;

  modport master (
    output io_glock, io_t_load, io_t_opcode, io_t_data, io_r_load, io_r_opcode,
    input  io_r_data, io_guard
  );

  modport slave (
    input  io_glock, io_t_load, io_t_opcode, io_t_data, io_r_load, io_r_opcode,
    output io_r_data, io_guard
  );
endinterface

// File: rtl/rf_nwr_nrd_guarded.sv
// rtl/rf_nwr_nrd_guarded.sv - NUM_WR/NUM_RD guarded TTA register file; RF_RD_BYPASS_EN enables read write-through
module rf_nwr_nrd_guarded #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_WR = 2,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  rf_nwr_nrd_guarded_if.slave bus
);

  logic [DATA_W-1:0]        rf      [DEPTH];
  logic [DATA_W-1:0]        r_data  [NUM_RD];
  logic [DEPTH-1:0]         wv;
  logic [DATA_W-1:0]        wd      [DEPTH];
  logic [NUM_RD-1:0]        rd_en;
  logic [ADDR_W-1:0]        rd_idx  [NUM_RD];
  logic [DATA_W-1:0]        rd_next [NUM_RD];
  logic [DEPTH-1:0]         guard;
  logic [NUM_RD*DATA_W-1:0] r_data_flat;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wv[i] = 1'b0;
      wd[i] = '0;
    end
    if (!bus.io_glock) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.io_t_load[k]) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (int'(bus.io_t_opcode[k*ADDR_W +: ADDR_W]) == i) begin
              wv[i] = 1'b1;
              wd[i] = bus.io_t_data[k*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_RD; j++) begin
      rd_en[j]   = bus.io_r_load[j] & ~bus.io_glock;
      rd_idx[j]  = bus.io_r_opcode[j*ADDR_W +: ADDR_W];
      rd_next[j] = '0;
      if (int'(rd_idx[j]) < DEPTH) begin
`ifdef RF_RD_BYPASS_EN
        rd_next[j] = wv[rd_idx[j]] ? wd[rd_idx[j]] : rf[rd_idx[j]];
`else
        rd_next[j] = rf[rd_idx[j]];
`endif
      end
    end
  end

  // Guard always sees the in-flight write so the interconnect can squash in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      guard[i] = wv[i] ? (wd[i] != '0) : (rf[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      for (int j = 0; j < NUM_RD; j++) r_data[j] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wv[i]) rf[i] <= wd[i];
      end
      for (int j = 0; j < NUM_RD; j++) begin
        if (rd_en[j]) r_data[j] <= rd_next[j];
      end
    end
  end

  always_comb begin
    r_data_flat = '0;
    for (int j = 0; j < NUM_RD; j++) r_data_flat[j*DATA_W +: DATA_W] = r_data[j];
  end

  assign bus.io_r_data = r_data_flat;
  assign bus.io_guard  = guard;

endmodule

// File: tb/tb_rf_nwr_nrd_guarded.sv
// tb/tb_rf_nwr_nrd_guarded.sv - scoreboard bench for rf_nwr_nrd_guarded at DEPTH 8 and DEPTH 6
module tb_rf_nwr_nrd_guarded;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  rf_nwr_nrd_guarded_if #(.DATA_W(32), .DEPTH(8), .NUM_WR(2), .NUM_RD(2)) bus8 ();
  rf_nwr_nrd_guarded_if #(.DATA_W(32), .DEPTH(6), .NUM_WR(2), .NUM_RD(2)) bus6 ();

  rf_nwr_nrd_guarded #(.DATA_W(32), .DEPTH(8), .NUM_WR(2), .NUM_RD(2)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave));
  rf_nwr_nrd_guarded #(.DATA_W(32), .DEPTH(6), .NUM_WR(2), .NUM_RD(2)) dut6 (
    .clk(clk), .reset(reset), .bus(bus6.slave));

  assign bus6.io_glock    = bus8.io_glock;
  assign bus6.io_t_load   = bus8.io_t_load;
  assign bus6.io_t_opcode = bus8.io_t_opcode;
  assign bus6.io_t_data   = bus8.io_t_data;
  assign bus6.io_r_load   = bus8.io_r_load;
  assign bus6.io_r_opcode = bus8.io_r_opcode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r8;
    logic [63:0] r6;
  } exp_t;
  exp_t sbq[$];

  // Reference: instance 0 has 8 registers, instance 1 has 6.
  logic [31:0] mrf [2][8];
  logic [31:0] mrd [2][2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic lk, input logic [1:0] tl,
                       input logic [2:0] to0, input logic [31:0] td0,
                       input logic [2:0] to1, input logic [31:0] td1,
                       input logic [1:0] rl, input logic [2:0] ro0, input logic [2:0] ro1);
    logic [2:0]  to [2];
    logic [31:0] td [2];
    logic [2:0]  ro [2];
    logic [31:0] old [8];
    logic [7:0]  g;
    logic [31:0] v;
    int          d;
    exp_t        e;
    to[0] = to0; to[1] = to1; td[0] = td0; td[1] = td1; ro[0] = ro0; ro[1] = ro1;
    @(negedge clk);
    reset             = rst;
    bus8.io_glock     = lk;
    bus8.io_t_load    = tl;
    bus8.io_t_opcode  = {to1, to0};
    bus8.io_t_data    = {td1, td0};
    bus8.io_r_load    = rl;
    bus8.io_r_opcode  = {ro1, ro0};
    #1;
    for (int inst = 0; inst < 2; inst++) begin
      d = (inst == 0) ? 8 : 6;
      g = '0;
      for (int i = 0; i < d; i++) begin
        v = mrf[inst][i];
        if (!lk)
          for (int k = 0; k < 2; k++)
            if (tl[k] && int'(to[k]) == i) v = td[k];
        g[i] = (v != 0);
      end
      if (!rst) begin
        if (inst == 0) chk("guard8", {56'b0, bus8.io_guard}, {56'b0, g});
        else           chk("guard6", {58'b0, bus6.io_guard}, {56'b0, g});
      end
      if (rst) begin
        for (int i = 0; i < 8; i++) mrf[inst][i] = '0;
        mrd[inst][0] = '0;
        mrd[inst][1] = '0;
      end else if (!lk) begin
        for (int i = 0; i < 8; i++) old[i] = mrf[inst][i];
        for (int k = 0; k < 2; k++)
          if (tl[k] && int'(to[k]) < d) mrf[inst][to[k]] = td[k];
        for (int j = 0; j < 2; j++) begin
          if (rl[j]) begin
            if (int'(ro[j]) >= d) mrd[inst][j] = '0;
`ifdef RF_RD_BYPASS_EN
            else mrd[inst][j] = mrf[inst][ro[j]];
`else
            else mrd[inst][j] = old[ro[j]];
`endif
          end
        end
      end
    end
    e.r8 = {mrd[0][1], mrd[0][0]};
    e.r6 = {mrd[1][1], mrd[1][0]};
    sbq.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rdata8", bus8.io_r_data, e.r8);
        chk("rdata6", {bus6.io_r_data}, e.r6);
      end
    end
  end

  function automatic logic [31:0] rnd_data();
    return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus8.io_glock = 1'b0; bus8.io_t_load = '0; bus8.io_t_opcode = '0;
    bus8.io_t_data = '0; bus8.io_r_load = '0; bus8.io_r_opcode = '0;
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 8; i++) mrf[n][i] = '0;

    cycle(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    cycle(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    chk("reset_guard", {56'b0, bus8.io_guard}, 64'h0);
    after_edge();
    chk("reset_rdata", bus8.io_r_data, 64'h0);

    cycle(0, 0, 2'b11, 3, 32'h12345678, 5, 32'h0, 2'b00, 0, 0);
    chk("par_guard3", {63'b0, bus8.io_guard[3]}, 64'h1);
    chk("par_guard5", {63'b0, bus8.io_guard[5]}, 64'h0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 3, 5);
    after_edge();
    chk("par_read", bus8.io_r_data, {32'h0, 32'h12345678});

    cycle(0, 0, 2'b11, 2, 32'hAAAA, 2, 32'h5555, 2'b00, 0, 0);
    chk("coll_guard2", {63'b0, bus8.io_guard[2]}, 64'h1);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2, 0);
    after_edge();
    chk("collision", {32'h0, bus8.io_r_data[31:0]}, 64'h5555);

    cycle(0, 1, 2'b01, 1, 32'h7, 0, 0, 2'b01, 1, 0);
    chk("lock_guard1", {63'b0, bus8.io_guard[1]}, 64'h0);
    after_edge();
    chk("lock_hold", {32'h0, bus8.io_r_data[31:0]}, 64'h5555);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0);
    after_edge();
    chk("lock_rf1", {32'h0, bus8.io_r_data[31:0]}, 64'h0);

    cycle(0, 0, 2'b01, 4, 32'h9, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 2'b01, 4, 32'hFF, 0, 0, 2'b01, 4, 0);
    after_edge();
`ifdef RF_RD_BYPASS_EN
    chk("same_cycle", {32'h0, bus8.io_r_data[31:0]}, 64'hFF);
`else
    chk("same_cycle", {32'h0, bus8.io_r_data[31:0]}, 64'h9);
`endif

    cycle(0, 0, 2'b01, 7, 32'hDEAD, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 7, 7);
    after_edge();
    chk("oor_read6", bus6.io_r_data, 64'h0);
    chk("oor_read8", {32'h0, bus8.io_r_data[31:0]}, 64'hDEAD);

    cycle(1, 1, 2'b11, 3, 32'h1, 4, 32'h2, 2'b11, 3, 4);
    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 3, 4);
    after_edge();
    chk("reset_in_lock", bus8.io_r_data, 64'h0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rnd_data(),
            3'($urandom_range(0, 7)), rnd_data(),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    cycle(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 64'(sbq.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_nwr_nrd_guarded.md
# rf_nwr_nrd_guarded

Parametrised multi-port TTA register file, successor to the single-bit 1-write/1-read guarded file. It provides `DEPTH` registers of `DATA_W` bits, `NUM_WR` trigger (write) ports and `NUM_RD` result (read) ports. Each read port has a registered output. One guard bit per register is exported to the interconnect's guard logic. The block sits on the TTA transport buses, and its state is frozen by the global lock.

## Interface
Parameters:
- `DATA_W`, default 32: register width.
- `DEPTH`, default 8: number of registers, minimum 2.
- `NUM_WR`, default 2: number of trigger (write) ports.
- `NUM_RD`, default 2: number of read ports.
- `ADDR_W`, default clog2(`DEPTH`): opcode width.

Ports:
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `io_glock`, in, 1: global lock; when 1, no state changes.
- `io_t_load`, in, `NUM_WR`: per-port write request.
- `io_t_opcode`, in, `NUM_WR*ADDR_W`: per-port write register index; port k occupies `[k*ADDR_W +: ADDR_W]`.
- `io_t_data`, in, `NUM_WR*DATA_W`: per-port write data, packed the same way.
- `io_r_load`, in, `NUM_RD`: per-port read request.
- `io_r_opcode`, in, `NUM_RD*ADDR_W`: per-port read register index.
- `io_r_data`, out, `NUM_RD*DATA_W`: per-port registered read result.
- `io_guard`, out, `DEPTH`: guard bit i is nonzero-test of register i, including write bypass.

## Operation
- **Register array:** `rf[0..DEPTH-1]`, all cleared to 0 on reset.
- **Write enable:** port k writes `rf[opcode_k] <= data_k` when `io_t_load[k]` is 1, `io_glock` is 0 and `opcode_k < DEPTH`.
- **Out-of-range opcode:** when `DEPTH` is not a power of two, a write to an index ≥ `DEPTH` is ignored.
- **Write collision:** if several ports write the same index in one cycle, the highest port index wins. Writes to different indices all take effect in the same cycle.
- **Read enable:** read port j updates its output register `r_data_j` when `io_r_load[j]` is 1 and `io_glock` is 0.
  - In-range index: `r_data_j` captures `rf[opcode_j]`, bypassed per the Configuration section.
  - Out-of-range index: `r_data_j` captures 0.
- **Read hold:** when `io_r_load[j]` is 0 or `io_glock` is 1, `r_data_j` holds its value.
- **Guard bit i:** `io_guard[i] = (wv_i ? wd_i : rf[i]) != 0`, combinational.
  - `wv_i` is 1 when a non-locked write to index i is present this cycle.
  - `wd_i` is the winning data under the collision rule.
  - Under `io_glock`, no bypass is applied: the guard shows `rf[i]` only.
- **Global lock:** when `io_glock` is 1, the register array and all `r_data` registers are frozen, whatever the load inputs are.

## Timing
- **Reset values:** all `rf` entries are 0, all `io_r_data` are 0, and `io_guard` is all zeros one cycle after `reset` is sampled high, provided no write is pending in that cycle.
- **Reset priority:** `reset` overrides writes and reads in the same cycle, including mid-lock. Writes asserted while `reset` is 1 are lost.
- **Write latency:** a write issued in cycle N is visible in `rf` from cycle N+1.
- **Guard latency:** zero cycles, because of the bypass. The guard reflects the write data already in cycle N.
- **Read latency:** one cycle. A request in cycle N drives `io_r_data` from cycle N+1 and holds it until the next unlocked read on that port.
- **Lock timing:** a lock asserted in cycle N suppresses every update at the edge that ends cycle N.

## Configuration
- `RF_RD_BYPASS_EN` defined: a read port that targets the same index as a same-cycle write captures the new (winning) write data, i.e. write-through.
- `RF_RD_BYPASS_EN` undefined: the read captures the pre-write `rf` value. The new value is readable from the following cycle.
- Guard bypass is present in both builds. The macro affects only the read-result registers.

## Test plan
- **Reset:** `DATA_W`=32, `DEPTH`=8. Hold `reset` for 2 cycles, then release → `io_r_data`=0 on both ports and `io_guard`=8'h00.
- **Parallel writes:** port 0 writes `rf[3]`=0x12345678 and port 1 writes `rf[5]`=0 in one cycle. Next cycle, read port 0 on index 3 and port 1 on index 5 → `io_r_data` = {0x00000000, 0x12345678} one cycle later. `io_guard[3]` was already 1 in the write cycle; `io_guard[5]` is 0.
- **Write collision:** both ports write index 2, port 0 with 0xAAAA and port 1 with 0x5555 → `rf[2]`=0x5555 and `io_guard[2]`=1.
- **Lock:** with `io_glock`=1, write `rf[1]`=7 and issue a read on port 0 → `rf[1]` is unchanged, `io_r_data` holds its value, and `io_guard[1]` does not bypass.
- **Same-cycle read and write:** `rf[4]` holds 9; in one cycle write `rf[4]`=0xFF and read index 4 → captured value is 0xFF with `RF_RD_BYPASS_EN` defined, 9 without it.
- **Out-of-range index:** `DEPTH`=6. Write to opcode 7, then read opcode 7 → no register changes and the read returns 0.
